// File: rtl/line_kcpe_conv2d_ctrl.sv
// Pass sequencer for one line_kcpe_conv2d_engine: weight load, pixel stream with
// psum feedback, drain of outstanding engine results, and psum writeback addressing.
module line_kcpe_conv2d_ctrl #(
    parameter int NUM_KCPE   = 3,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int PASS_WIDTH = 8,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_cfg_line_len,
    input  logic [PASS_WIDTH-1:0] i_cfg_num_pass,
    input  logic [ADDR_WIDTH-1:0] i_cfg_data_base,
    input  logic [ADDR_WIDTH-1:0] i_cfg_wght_base,
    input  logic                  i_stall,
    input  logic                  i_eng_psum_val,
    output logic [ADDR_WIDTH-1:0] o_weight_addr,
    output logic                  o_weight_val,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic                  o_data_val,
    output logic [CNT_WIDTH-1:0]  o_psum_addr,
    output logic                  o_psum_val,
    output logic [CNT_WIDTH-1:0]  o_wb_addr,
    output logic                  o_wb_en,
    output logic                  o_wb_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [REG_WIDTH-1:0]  err_start_busy,
    output logic [REG_WIDTH-1:0]  err_psum_val
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int KW = $clog2(NUM_KCPE + 1);
    localparam logic [KW-1:0] KCNT_LAST = KW'(NUM_KCPE - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  line_len_q, line_len_d;
    logic [PASS_WIDTH-1:0] num_pass_q, num_pass_d;
    logic [PASS_WIDTH-1:0] pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] dptr_q, dptr_d;
    logic [KW-1:0]         kcnt_q, kcnt_d;
    logic [CNT_WIDTH-1:0]  x_q, x_d;
    logic [CNT_WIDTH-1:0]  outs_q, outs_d;
    logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0] weight_addr_q, weight_addr_d;
    logic                  weight_val_q, weight_val_d;
    logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
    logic                  data_val_q, data_val_d;
    logic [CNT_WIDTH-1:0]  psum_addr_q, psum_addr_d;
    logic                  psum_val_q, psum_val_d;
    logic [CNT_WIDTH-1:0]  wb_addr_q, wb_addr_d;
    logic                  wb_en_q, wb_en_d;
    logic                  wb_last_q, wb_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [REG_WIDTH-1:0]  err_start_busy_q, err_start_busy_d;
    logic [REG_WIDTH-1:0]  err_psum_val_q, err_psum_val_d;
    logic                  psum_ok;

    // Every issue is decided one cycle ahead so that address and val leave a flop together;
    // IDLE therefore issues the first weight word itself on i_start.
    always_comb begin
        state_d          = state_q;
        line_len_d       = line_len_q;
        num_pass_d       = num_pass_q;
        pass_d           = pass_q;
        wptr_d           = wptr_q;
        dptr_d           = dptr_q;
        kcnt_d           = kcnt_q;
        x_d              = x_q;
        outs_d           = outs_q;
        wcnt_d           = wcnt_q;
        weight_addr_d    = weight_addr_q;
        weight_val_d     = 1'b0;
        data_addr_d      = data_addr_q;
        data_val_d       = 1'b0;
        psum_addr_d      = psum_addr_q;
        psum_val_d       = 1'b0;
        wb_addr_d        = wb_addr_q;
        wb_en_d          = 1'b0;
        wb_last_d        = 1'b0;
        done_d           = 1'b0;
        err_start_busy_d = err_start_busy_q;
        err_psum_val_d   = err_psum_val_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    line_len_d = i_cfg_line_len;
                    num_pass_d = i_cfg_num_pass;
                    pass_d     = '0;
                    wptr_d     = i_cfg_wght_base;
                    dptr_d     = i_cfg_data_base;
                    kcnt_d     = '0;
                    x_d        = '0;
                    wcnt_d     = '0;
                    if (i_cfg_line_len == '0 || i_cfg_num_pass == '0) begin
                        state_d = S_DONE;
                    end else begin
                        weight_val_d  = 1'b1;
                        weight_addr_d = i_cfg_wght_base;
                        wptr_d        = i_cfg_wght_base + 1'b1;
                        if (KCNT_LAST == '0) begin
                            state_d = S_STREAM;
                        end else begin
                            kcnt_d  = KW'(1);
                            state_d = S_LOAD_W;
                        end
                    end
                end
            end
            S_LOAD_W: begin
                if (!i_stall) begin
                    weight_val_d  = 1'b1;
                    weight_addr_d = wptr_q;
                    wptr_d        = wptr_q + 1'b1;
                    if (kcnt_q == KCNT_LAST) begin
                        kcnt_d  = '0;
                        state_d = S_STREAM;
                    end else begin
                        kcnt_d = kcnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (!i_stall) begin
                    data_val_d  = 1'b1;
                    data_addr_d = dptr_q;
                    psum_addr_d = x_q;
                    psum_val_d  = (pass_q != '0);
                    dptr_d      = dptr_q + 1'b1;
                    if (x_q == line_len_q - 1'b1) begin
                        x_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (outs_q == '0) begin
                    pass_d  = pass_q + 1'b1;
                    wcnt_d  = '0;
                    state_d = (pass_q + 1'b1 == num_pass_q) ? S_DONE : S_LOAD_W;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                wcnt_d  = '0;
                pass_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Returns with nothing outstanding are treated as spurious and never written back.
        psum_ok = i_eng_psum_val && (outs_q != '0);
        if (psum_ok) begin
            wb_en_d   = 1'b1;
            wb_addr_d = wcnt_q;
            wcnt_d    = wcnt_q + 1'b1;
            wb_last_d = (pass_q == num_pass_q - 1'b1);
        end

        if (data_val_d && !psum_ok) begin
            outs_d = outs_q + 1'b1;
        end else if (!data_val_d && psum_ok) begin
            outs_d = outs_q - 1'b1;
        end

        if (i_eng_psum_val && outs_q == '0 && err_psum_val_q != '1) begin
            err_psum_val_d = err_psum_val_q + 1'b1;
        end
        if (i_start && busy_q && err_start_busy_q != '1) begin
            err_start_busy_d = err_start_busy_q + 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            line_len_q       <= '0;
            num_pass_q       <= '0;
            pass_q           <= '0;
            wptr_q           <= '0;
            dptr_q           <= '0;
            kcnt_q           <= '0;
            x_q              <= '0;
            outs_q           <= '0;
            wcnt_q           <= '0;
            weight_addr_q    <= '0;
            weight_val_q     <= 1'b0;
            data_addr_q      <= '0;
            data_val_q       <= 1'b0;
            psum_addr_q      <= '0;
            psum_val_q       <= 1'b0;
            wb_addr_q        <= '0;
            wb_en_q          <= 1'b0;
            wb_last_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_start_busy_q <= '0;
            err_psum_val_q   <= '0;
        end else begin
            state_q          <= state_d;
            line_len_q       <= line_len_d;
            num_pass_q       <= num_pass_d;
            pass_q           <= pass_d;
            wptr_q           <= wptr_d;
            dptr_q           <= dptr_d;
            kcnt_q           <= kcnt_d;
            x_q              <= x_d;
            outs_q           <= outs_d;
            wcnt_q           <= wcnt_d;
            weight_addr_q    <= weight_addr_d;
            weight_val_q     <= weight_val_d;
            data_addr_q      <= data_addr_d;
            data_val_q       <= data_val_d;
            psum_addr_q      <= psum_addr_d;
            psum_val_q       <= psum_val_d;
            wb_addr_q        <= wb_addr_d;
            wb_en_q          <= wb_en_d;
            wb_last_q        <= wb_last_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_start_busy_q <= err_start_busy_d;
            err_psum_val_q   <= err_psum_val_d;
        end
    end

    assign o_weight_addr  = weight_addr_q;
    assign o_weight_val   = weight_val_q;
    assign o_data_addr    = data_addr_q;
    assign o_data_val     = data_val_q;
    assign o_psum_addr    = psum_addr_q;
    assign o_psum_val     = psum_val_q;
    assign o_wb_addr      = wb_addr_q;
    assign o_wb_en        = wb_en_q;
    assign o_wb_last      = wb_last_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign err_start_busy = err_start_busy_q;
    assign err_psum_val   = err_psum_val_q;

endmodule

// File: tb/tb_line_kcpe_conv2d_ctrl.sv
// Directed bench for line_kcpe_conv2d_ctrl with a fixed 3-cycle engine model
// feeding i_eng_psum_val back from o_data_val.
module tb_line_kcpe_conv2d_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_cfg_line_len = '0;
    logic [7:0]  i_cfg_num_pass = '0;
    logic [15:0] i_cfg_data_base = '0;
    logic [15:0] i_cfg_wght_base = '0;
    logic        i_stall = 1'b0;
    logic        stray_psum = 1'b0;
    logic        eng_psum_val;
    logic [15:0] o_weight_addr, o_data_addr, o_psum_addr, o_wb_addr;
    logic        o_weight_val, o_data_val, o_psum_val, o_wb_en, o_wb_last, o_busy, o_done;
    logic [31:0] err_start_busy, err_psum_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int first_w_cyc = 0;
    int done_cnt = 0;
    int stall_viol = 0;
    int lat1 = 0;
    logic stall_prev = 1'b0;
    logic [2:0] eng_sr;

    logic [15:0] wq[$];
    logic [15:0] dq[$];
    logic [15:0] pq[$];
    logic        pvq[$];
    logic [15:0] wbq[$];
    logic        wblq[$];

    line_kcpe_conv2d_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_cfg_line_len (i_cfg_line_len),
        .i_cfg_num_pass (i_cfg_num_pass),
        .i_cfg_data_base(i_cfg_data_base),
        .i_cfg_wght_base(i_cfg_wght_base),
        .i_stall        (i_stall),
        .i_eng_psum_val (eng_psum_val),
        .o_weight_addr  (o_weight_addr),
        .o_weight_val   (o_weight_val),
        .o_data_addr    (o_data_addr),
        .o_data_val     (o_data_val),
        .o_psum_addr    (o_psum_addr),
        .o_psum_val     (o_psum_val),
        .o_wb_addr      (o_wb_addr),
        .o_wb_en        (o_wb_en),
        .o_wb_last      (o_wb_last),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .err_start_busy (err_start_busy),
        .err_psum_val   (err_psum_val)
    );

    always #5 clk = ~clk;

    // Engine stand-in: each data beat comes back as a result three cycles later.
    always @(posedge clk or negedge rst) begin
        if (!rst) eng_sr <= '0;
        else      eng_sr <= {eng_sr[1:0], o_data_val};
    end
    assign eng_psum_val = eng_sr[2] | stray_psum;

    always @(posedge clk) stall_prev <= i_stall;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (i_start) start_cyc = cyc;
        if (o_weight_val) begin
            if (wq.size() == 0) first_w_cyc = cyc;
            wq.push_back(o_weight_addr);
        end
        if (o_data_val) begin
            dq.push_back(o_data_addr);
            pq.push_back(o_psum_addr);
            pvq.push_back(o_psum_val);
        end
        if (o_wb_en) begin
            wbq.push_back(o_wb_addr);
            wblq.push_back(o_wb_last);
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (stall_prev && (o_data_val || o_weight_val)) stall_viol = stall_viol + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq.delete(); dq.delete(); pq.delete(); pvq.delete(); wbq.delete(); wblq.delete();
        done_cnt = 0;
        stall_viol = 0;
        first_w_cyc = 0;
    endtask

    task automatic pulse_start(input logic [15:0] ll, input logic [7:0] np,
                               input logic [15:0] db, input logic [15:0] wb);
        i_cfg_line_len  = ll;
        i_cfg_num_pass  = np;
        i_cfg_data_base = db;
        i_cfg_wght_base = wb;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_cfg_line_len  = 16'hFFFF;
        i_cfg_num_pass  = 8'hFF;
        i_cfg_data_base = 16'hDEAD;
        i_cfg_wght_base = 16'hBEEF;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: o_done pulses 0, required 1", name);
        end
        repeat (4) tick();
    endtask

    task automatic wait_data(input string name, input int n);
        int k;
        k = 0;
        while (dq.size() < n && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (dq.size() < n) begin
            errors++;
            $display("[TB] FAIL %s_data_wait: data beats %0d, required %0d", name, dq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({o_weight_val, o_data_val, o_psum_val, o_wb_en, o_wb_last, o_busy, o_done} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, required 0",
                     {o_weight_val, o_data_val, o_psum_val, o_wb_en, o_wb_last, o_busy, o_done});
        end
        checks++;
        if ({o_weight_addr, o_data_addr, o_psum_addr, o_wb_addr, err_start_busy, err_psum_val} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: addresses/err not all zero (w=%h d=%h p=%h wb=%h)",
                     o_weight_addr, o_data_addr, o_psum_addr, o_wb_addr);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start(16'd4, 8'd2, 16'h0100, 16'h0020);
        wait_done("basic");
        lat1 = done_cyc - start_cyc;
        checks++;
        if (first_w_cyc - start_cyc != 1) begin
            errors++;
            $display("[TB] FAIL basic_first_weight_latency: got %0d, required 1", first_w_cyc - start_cyc);
        end
        checks++;
        if (wq.size() != 6) begin
            errors++;
            $display("[TB] FAIL basic_weight_count: got %0d, required 6", wq.size());
        end
        for (int i = 0; i < wq.size() && i < 6; i++) begin
            checks++;
            if (wq[i] !== 16'h0020 + 16'(i)) begin
                errors++;
                $display("[TB] FAIL basic_weight_addr[%0d]: got %h, required %h", i, wq[i], 16'h0020 + 16'(i));
            end
        end
        checks++;
        if (dq.size() != 8) begin
            errors++;
            $display("[TB] FAIL basic_data_count: got %0d, required 8", dq.size());
        end
        for (int i = 0; i < dq.size() && i < 8; i++) begin
            checks++;
            if (dq[i] !== 16'h0100 + 16'(i) || pvq[i] !== (i >= 4) || pq[i] !== 16'(i % 4)) begin
                errors++;
                $display("[TB] FAIL basic_data[%0d]: got addr %h psum_val %b psum_addr %0d, required %h %b %0d",
                         i, dq[i], pvq[i], pq[i], 16'h0100 + 16'(i), (i >= 4), i % 4);
            end
        end
        checks++;
        if (wbq.size() != 8) begin
            errors++;
            $display("[TB] FAIL basic_wb_count: got %0d, required 8", wbq.size());
        end
        for (int i = 0; i < wbq.size() && i < 8; i++) begin
            checks++;
            if (wbq[i] !== 16'(i % 4) || wblq[i] !== (i >= 4)) begin
                errors++;
                $display("[TB] FAIL basic_wb[%0d]: got addr %0d last %b, required %0d %b",
                         i, wbq[i], wblq[i], i % 4, (i >= 4));
            end
        end
        checks++;
        if (done_cnt != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: got pulses %0d busy %b, required 1 0", done_cnt, o_busy);
        end
    endtask

    task automatic test_stall();
        clear_log();
        pulse_start(16'd4, 8'd2, 16'h0100, 16'h0020);
        wait_data("stall", 2);
        i_stall = 1'b1;
        repeat (2) tick();
        i_stall = 1'b0;
        wait_done("stall");
        checks++;
        if (done_cyc - start_cyc != lat1 + 2) begin
            errors++;
            $display("[TB] FAIL stall_done_latency: got %0d, required %0d", done_cyc - start_cyc, lat1 + 2);
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("[TB] FAIL stall_val_during_stall: got %0d vals, required 0", stall_viol);
        end
        checks++;
        if (dq.size() != 8 || wq.size() != 6) begin
            errors++;
            $display("[TB] FAIL stall_counts: got data %0d weights %0d, required 8 6", dq.size(), wq.size());
        end
        for (int i = 0; i < dq.size() && i < 8; i++) begin
            checks++;
            if (dq[i] !== 16'h0100 + 16'(i)) begin
                errors++;
                $display("[TB] FAIL stall_data_addr[%0d]: got %h, required %h", i, dq[i], 16'h0100 + 16'(i));
            end
        end
        checks++;
        if (wbq.size() != 8) begin
            errors++;
            $display("[TB] FAIL stall_wb_count: got %0d, required 8", wbq.size());
        end
    endtask

    task automatic test_zero();
        clear_log();
        pulse_start(16'd0, 8'd2, 16'h0100, 16'h0020);
        repeat (5) tick();
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != 2) begin
            errors++;
            $display("[TB] FAIL zero_len_done: got pulses %0d at +%0d, required 1 at +2", done_cnt, done_cyc - start_cyc);
        end
        checks++;
        if (wq.size() + dq.size() + wbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_len_activity: got %0d events, required 0", wq.size() + dq.size() + wbq.size());
        end
        clear_log();
        pulse_start(16'd4, 8'd0, 16'h0100, 16'h0020);
        repeat (5) tick();
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != 2) begin
            errors++;
            $display("[TB] FAIL zero_pass_done: got pulses %0d at +%0d, required 1 at +2", done_cnt, done_cyc - start_cyc);
        end
        checks++;
        if (wq.size() + dq.size() + wbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_pass_activity: got %0d events, required 0", wq.size() + dq.size() + wbq.size());
        end
    endtask

    task automatic test_errors();
        clear_log();
        pulse_start(16'd4, 8'd2, 16'h0100, 16'h0020);
        wait_data("err", 1);
        pulse_start(16'd7, 8'd1, 16'h0900, 16'h0990);
        wait_done("err");
        checks++;
        if (err_start_busy !== 32'd1) begin
            errors++;
            $display("[TB] FAIL err_start_busy: got %0d, required 1", err_start_busy);
        end
        checks++;
        if (dq.size() != 8 || wq.size() != 6 || wbq.size() != 8 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL err_busy_sequence: got d%0d w%0d wb%0d done%0d, required 8 6 8 1",
                     dq.size(), wq.size(), wbq.size(), done_cnt);
        end
        checks++;
        if (dq.size() == 8 && dq[7] !== 16'h0107) begin
            errors++;
            $display("[TB] FAIL err_busy_last_addr: got %h, required 0107", dq[7]);
        end
        clear_log();
        stray_psum = 1'b1;
        tick();
        stray_psum = 1'b0;
        repeat (3) tick();
        checks++;
        if (err_psum_val !== 32'd1) begin
            errors++;
            $display("[TB] FAIL err_psum_val: got %0d, required 1", err_psum_val);
        end
        checks++;
        if (wbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL err_psum_no_wb: got %0d writes, required 0", wbq.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start(16'd4, 8'd2, 16'h0100, 16'h0020);
        wait_data("rstmid", 2);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({o_weight_val, o_data_val, o_psum_val, o_wb_en, o_busy, o_done} !== 6'b0 ||
            o_data_addr !== 16'h0 || err_start_busy !== 32'd0 || err_psum_val !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got flags %b daddr %h errs %0d %0d, required all 0",
                     {o_weight_val, o_data_val, o_psum_val, o_wb_en, o_busy, o_done},
                     o_data_addr, err_start_busy, err_psum_val);
        end
        tick();
        rst = 1'b1;
        tick();
        clear_log();
        pulse_start(16'd2, 8'd1, 16'h0200, 16'h0040);
        wait_done("rstmid");
        checks++;
        if (wq.size() != 3 || wq[0] !== 16'h0040 || wq[2] !== 16'h0042) begin
            errors++;
            $display("[TB] FAIL rstmid_weights: got %0d words, required 3 at 0040..0042", wq.size());
        end
        checks++;
        if (dq.size() != 2 || dq[0] !== 16'h0200 || dq[1] !== 16'h0201 || pvq[0] !== 1'b0 || pvq[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_data: got %0d beats, required 2 at 0200..0201 without psum_val", dq.size());
        end
        checks++;
        if (wbq.size() != 2 || wbq[0] !== 16'd0 || wbq[1] !== 16'd1 || wblq[0] !== 1'b1 || wblq[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_wb: got %0d writes, required 2 at 0,1 both last", wbq.size());
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL rstmid_done: got %0d pulses, required 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
